// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared widths, FSM state encoding and length helper for the UDP TX path
//
// Purpose : common definitions imported by udp_tx_scheduler and rr_arbiter.
// Contents: UDP_PORT_W / UDP_LEN_W / UDP_WORD_W field widths, the scheduler
//           state enum, and udp_words_from_len() which converts a byte length
//           into a count of 32-bit payload words.
package udp_pkg;

  localparam int UDP_PORT_W  = 16;
  localparam int UDP_LEN_W   = 16;
  localparam int UDP_WORD_W  = 32;
  // ceil(0xFFFF / 4) = 0x4000 needs 15 bits
  localparam int UDP_WORDS_W = UDP_LEN_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_STREAM   = 3'd2,
    ST_WAIT_FIN = 3'd3,
    ST_DONE     = 3'd4
  } udp_tx_state_e;

  // (len + 3) >> 2 done in 17 bits so 0xFFFF rounds up to 0x4000 instead of wrapping
  function automatic logic [UDP_WORDS_W-1:0] udp_words_from_len(input logic [UDP_LEN_W-1:0] len);
    logic [UDP_LEN_W:0] sum;
    sum = {1'b0, len} + {{(UDP_LEN_W-1){1'b0}}, 2'd3};
    return sum[UDP_LEN_W:2];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot round-robin picker
//
// Purpose : selects the first requester after last_grant, wrapping around.
// Ports   : req        in  N_REQ  request vector
//           last_grant in  IDX_W  index of the most recently served requester
//           pick       out N_REQ  one-hot winner, all zero when req is zero
module rr_arbiter
  import udp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] pick
);

  int   idx;
  logic found;

  // Walk offsets 1..N_REQ from last_grant; the first requesting index wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - round-robin sharing of one UDP encoder among N_REQ requesters
//
// Purpose : arbitrates requesters, latches the winner's header onto the encoder,
//           pulses enc_start, streams payload words and returns a done pulse
//           once the encoder reports fin.
// Ports   : clk, reset (sync, active-high)
//           req / req_src_port / req_dest_port / req_len / req_no_chksum  per-requester header
//           req_data / req_data_valid / req_data_ready                    per-requester payload
//           grant, done, error                                            status back to requesters
//           enc_src_port / enc_dest_port / enc_len / enc_no_chksum /
//           enc_start / enc_data / enc_data_av                            to the encoder
//           enc_fin                                                       from the encoder
// Config  : define UDP_TX_SCHED_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module udp_tx_scheduler
  import udp_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [UDP_PORT_W*N_REQ-1:0] req_src_port,
  input  logic [UDP_PORT_W*N_REQ-1:0] req_dest_port,
  input  logic [UDP_LEN_W*N_REQ-1:0]  req_len,
  input  logic [N_REQ-1:0]            req_no_chksum,
  input  logic [UDP_WORD_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]            req_data_valid,
  output logic [N_REQ-1:0]            req_data_ready,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        error,
  output logic [UDP_PORT_W-1:0]       enc_src_port,
  output logic [UDP_PORT_W-1:0]       enc_dest_port,
  output logic [UDP_LEN_W-1:0]        enc_len,
  output logic                        enc_no_chksum,
  output logic                        enc_start,
  output logic [UDP_WORD_W-1:0]       enc_data,
  output logic                        enc_data_av,
  input  logic                        enc_fin
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_START    = ST_START;
  localparam logic [2:0] S_STREAM   = ST_STREAM;
  localparam logic [2:0] S_WAIT_FIN = ST_WAIT_FIN;
  localparam logic [2:0] S_DONE     = ST_DONE;

  logic [2:0]             state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [UDP_PORT_W-1:0]  src_q, src_d, dest_q, dest_d;
  logic [UDP_LEN_W-1:0]   len_q, len_d;
  logic                   no_chk_q, no_chk_d;
  logic [UDP_WORDS_W-1:0] words_q, words_d, words_nxt;
  logic                   fin_seen_q, fin_seen_d;

  logic [IDX_W-1:0]       g_idx;
  logic [UDP_WORD_W-1:0]  g_data;
  logic                   g_valid;
  logic                   in_done, data_phase, xfer, load, expire;
  logic [N_REQ-1:0]       arb_req, pick;
  logic [IDX_W-1:0]       arb_last;
  logic [UDP_PORT_W-1:0]  pick_src, pick_dest;
  logic [UDP_LEN_W-1:0]   pick_len;
  logic                   pick_no_chk;

  // Payload mux for the current owner.
  always_comb begin
    g_idx   = '0;
    g_data  = '0;
    g_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx   = IDX_W'(i);
        g_data  = req_data[i*UDP_WORD_W +: UDP_WORD_W];
        g_valid = req_data_valid[i];
      end
    end
  end

  // Arbitration also runs in DONE so the next owner starts one cycle sooner.
  // The finishing requester still holds req that cycle, so it is masked out
  // and rotation proceeds from it as if last_grant had already been updated.
  assign in_done  = (state_q == S_DONE);
  assign arb_req  = req & ~(in_done ? grant_q : '0);
  assign arb_last = in_done ? g_idx : last_grant_q;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req        (arb_req),
    .last_grant (arb_last),
    .pick       (pick)
  );

  always_comb begin
    pick_src    = '0;
    pick_dest   = '0;
    pick_len    = '0;
    pick_no_chk = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_src    = req_src_port[i*UDP_PORT_W +: UDP_PORT_W];
        pick_dest   = req_dest_port[i*UDP_PORT_W +: UDP_PORT_W];
        pick_len    = req_len[i*UDP_LEN_W +: UDP_LEN_W];
        pick_no_chk = req_no_chksum[i];
      end
    end
  end

  assign data_phase = ((state_q == S_START) || (state_q == S_STREAM)) && (words_q != '0);
  assign xfer       = data_phase & g_valid;
  assign words_nxt  = words_q - UDP_WORDS_W'(xfer);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    dest_d       = dest_q;
    len_d        = len_q;
    no_chk_d     = no_chk_q;
    words_d      = words_q;
    fin_seen_d   = fin_seen_q;
    load         = 1'b0;
    case (state_q)
      S_IDLE: load = |pick;
      // len==0 starts with words_q==0, so it falls straight through to WAIT_FIN.
      S_START, S_STREAM: begin
        words_d = words_nxt;
        if (enc_fin) fin_seen_d = 1'b1;
        state_d = (words_nxt == '0) ? S_WAIT_FIN : S_STREAM;
      end
      S_WAIT_FIN: if (enc_fin || fin_seen_q) state_d = S_DONE;
      S_DONE: begin
        last_grant_d = g_idx;
        grant_d      = '0;
        fin_seen_d   = 1'b0;
        state_d      = S_IDLE;
        load         = |pick;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      grant_d    = pick;
      src_d      = pick_src;
      dest_d     = pick_dest;
      len_d      = pick_len;
      no_chk_d   = pick_no_chk;
      words_d    = udp_words_from_len(pick_len);
      fin_seen_d = 1'b0;
      state_d    = S_START;
    end
    if (expire) state_d = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      src_q        <= '0;
      dest_q       <= '0;
      len_q        <= '0;
      no_chk_q     <= 1'b0;
      words_q      <= '0;
      fin_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      dest_q       <= dest_d;
      len_q        <= len_d;
      no_chk_q     <= no_chk_d;
      words_q      <= words_d;
      fin_seen_q   <= fin_seen_d;
    end
  end

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             active;

  // Counter is zero on the START cycle, so expiry lands DONE exactly
  // TIMEOUT_CYCLES cycles after START.
  assign active = (state_q == S_START) || (state_q == S_STREAM) || (state_q == S_WAIT_FIN);
  assign expire = active && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d   = active ? (cnt_q + CNT_W'(1)) : '0;
    abort_d = expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign error = in_done & abort_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign expire = 1'b0;
  assign error  = 1'b0;
`endif

  assign grant          = grant_q;
  assign done           = in_done ? grant_q : '0;
  assign req_data_ready = data_phase ? grant_q : '0;
  assign enc_src_port   = src_q;
  assign enc_dest_port  = dest_q;
  assign enc_len        = len_q;
  assign enc_no_chksum  = no_chk_q;
  assign enc_start      = (state_q == S_START);
  assign enc_data_av    = xfer;
  assign enc_data       = xfer ? g_data : '0;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - directed self-checking bench for udp_tx_scheduler
module tb_udp_tx_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [16*N-1:0] req_src_port, req_dest_port, req_len;
  logic [N-1:0]  req_no_chksum;
  logic [32*N-1:0] req_data;
  logic [N-1:0]  req_data_valid, req_data_ready, grant, done;
  logic          error;
  logic [15:0]   enc_src_port, enc_dest_port, enc_len;
  logic          enc_no_chksum, enc_start, enc_data_av, enc_fin;
  logic [31:0]   enc_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  udp_tx_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_src_port(req_src_port), .req_dest_port(req_dest_port), .req_len(req_len),
    .req_no_chksum(req_no_chksum), .req_data(req_data), .req_data_valid(req_data_valid),
    .req_data_ready(req_data_ready), .grant(grant), .done(done), .error(error),
    .enc_src_port(enc_src_port), .enc_dest_port(enc_dest_port), .enc_len(enc_len),
    .enc_no_chksum(enc_no_chksum), .enc_start(enc_start), .enc_data(enc_data),
    .enc_data_av(enc_data_av), .enc_fin(enc_fin)
  );

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = '0; req_src_port = '0; req_dest_port = '0; req_len = '0;
    req_no_chksum = '0; req_data = '0; req_data_valid = '0; enc_fin = 1'b0;
  endtask

  task automatic set_hdr(input int r, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic nc);
    req_src_port[16*r +: 16]  = s;
    req_dest_port[16*r +: 16] = d;
    req_len[16*r +: 16]       = l;
    req_no_chksum[r]          = nc;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs;
    reset = 1'b1;
    req = 4'b1111;
    req_data_valid = 4'b1111;
    step;
    step;
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++; if (enc_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", enc_start); end
    checks++; if (req_data_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_data_ready); end
    checks++; if (enc_data_av !== 1'b0 || enc_data !== 32'h0) begin failures++; $display("FAIL reset_data av=%b data=%h exp 0/0", enc_data_av, enc_data); end
    checks++; if (enc_len !== 16'h0 || enc_src_port !== 16'h0 || enc_dest_port !== 16'h0) begin failures++; $display("FAIL reset_hdr len=%h src=%h dst=%h exp 0", enc_len, enc_src_port, enc_dest_port); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    clear_inputs;
    reset = 1'b0;
    step;
  endtask

  task automatic test_hello;
    logic [31:0] w [3];
    w[0] = 32'h48656c6c; w[1] = 32'h6f20576f; w[2] = 32'h726c6400;
    set_hdr(1, 16'ha08f, 16'h2694, 16'd11, 1'b0);
    req[1] = 1'b1; req_data_valid[1] = 1'b1; req_data[32*1 +: 32] = w[0];
    #1;
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL hello_idle_grant got=%b exp=0000", grant); end
    step;
    checks++; if (enc_start !== 1'b1) begin failures++; $display("FAIL hello_start got=%b exp=1", enc_start); end
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL hello_grant got=%b exp=0010", grant); end
    checks++; if (enc_src_port !== 16'ha08f || enc_dest_port !== 16'h2694 || enc_len !== 16'd11 || enc_no_chksum !== 1'b0) begin failures++; $display("FAIL hello_hdr src=%h dst=%h len=%h nc=%b exp a08f/2694/000b/0", enc_src_port, enc_dest_port, enc_len, enc_no_chksum); end
    checks++; if (enc_data_av !== 1'b1 || enc_data !== w[0] || req_data_ready !== 4'b0010) begin failures++; $display("FAIL hello_w0 av=%b data=%h rdy=%b exp 1/%h/0010", enc_data_av, enc_data, req_data_ready, w[0]); end
    for (int k = 1; k < 3; k++) begin
      step;
      req_data[32*1 +: 32] = w[k];
      #1;
      checks++; if (enc_start !== 1'b0 || enc_data_av !== 1'b1 || enc_data !== w[k]) begin failures++; $display("FAIL hello_w%0d start=%b av=%b data=%h exp 0/1/%h", k, enc_start, enc_data_av, enc_data, w[k]); end
    end
    step;
    checks++; if (enc_data_av !== 1'b0 || req_data_ready !== 4'b0 || done !== 4'b0) begin failures++; $display("FAIL hello_wait av=%b rdy=%b done=%b exp 0/0000/0000", enc_data_av, req_data_ready, done); end
    enc_fin = 1'b1;
    step;
    enc_fin = 1'b0;
    checks++; if (done !== 4'b0010 || error !== 1'b0) begin failures++; $display("FAIL hello_done done=%b err=%b exp 0010/0", done, error); end
    checks++; if (enc_len !== 16'd11) begin failures++; $display("FAIL hello_hdr_stable len=%h exp=000b", enc_len); end
    clear_inputs;
    step;
    checks++; if (done !== 4'b0 || grant !== 4'b0) begin failures++; $display("FAIL hello_idle_after done=%b grant=%b exp 0000/0000", done, grant); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    do_reset;
    for (int r = 0; r < N; r++) begin
      set_hdr(r, 16'h1000 + 16'(r), 16'h2000 + 16'(r), 16'd4, 1'b0);
      req_data[32*r +: 32] = 32'hc0de0000 + 32'(r);
    end
    req = 4'b1111; req_data_valid = 4'b1111;
    step;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      checks++; if (grant !== exp_g || enc_start !== 1'b1 || enc_data !== 32'hc0de0000 + 32'(k % 4)) begin failures++; $display("FAIL rr_grant_%0d grant=%b start=%b data=%h exp %b/1/%h", k, grant, enc_start, enc_data, exp_g, 32'hc0de0000 + 32'(k % 4)); end
      step;
      enc_fin = 1'b1;
      step;
      enc_fin = 1'b0;
      checks++; if (done !== exp_g) begin failures++; $display("FAIL rr_done_%0d got=%b exp=%b", k, done, exp_g); end
      // requester 0 keeps req high through its first done: an immediate re-request
      if (k != 0) begin req[k % 4] = 1'b0; req_data_valid[k % 4] = 1'b0; end
      step;
    end
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL rr_idle_grant got=%b exp=0000", grant); end
    clear_inputs;
  endtask

  task automatic test_gap;
    int xfers;
    xfers = 0;
    set_hdr(2, 16'h1111, 16'h2222, 16'd9, 1'b1);
    req[2] = 1'b1; req_data_valid[2] = 1'b1; req_data[32*2 +: 32] = 32'hd0000000;
    step;
    checks++; if (enc_data_av !== 1'b1 || enc_data !== 32'hd0000000 || enc_no_chksum !== 1'b1) begin failures++; $display("FAIL gap_w0 av=%b data=%h nc=%b exp 1/d0000000/1", enc_data_av, enc_data, enc_no_chksum); end
    if (enc_data_av === 1'b1) xfers++;
    for (int k = 0; k < 2; k++) begin
      step;
      req_data_valid[2] = 1'b0;
      #1;
      checks++; if (enc_data_av !== 1'b0 || req_data_ready !== 4'b0100) begin failures++; $display("FAIL gap_hole%0d av=%b rdy=%b exp 0/0100", k, enc_data_av, req_data_ready); end
      if (enc_data_av === 1'b1) xfers++;
    end
    for (int k = 1; k < 3; k++) begin
      step;
      req_data_valid[2] = 1'b1; req_data[32*2 +: 32] = 32'hd0000000 + 32'(k);
      if (k == 2) enc_fin = 1'b1;
      #1;
      checks++; if (enc_data_av !== 1'b1 || enc_data !== 32'hd0000000 + 32'(k)) begin failures++; $display("FAIL gap_w%0d av=%b data=%h exp 1/%h", k, enc_data_av, enc_data, 32'hd0000000 + 32'(k)); end
      if (enc_data_av === 1'b1) xfers++;
    end
    step;
    enc_fin = 1'b0;
    #1;
    checks++; if (req_data_ready !== 4'b0 || enc_data_av !== 1'b0 || done !== 4'b0) begin failures++; $display("FAIL gap_wait rdy=%b av=%b done=%b exp 0000/0/0000", req_data_ready, enc_data_av, done); end
    if (enc_data_av === 1'b1) xfers++;
    checks++; if (xfers != 3) begin failures++; $display("FAIL gap_xfers got=%0d exp=3", xfers); end
    step;
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL gap_done got=%b exp=0100", done); end
    clear_inputs;
    step;
  endtask

  task automatic test_len_zero;
    set_hdr(3, 16'h3333, 16'h4444, 16'd0, 1'b0);
    req[3] = 1'b1; req_data_valid[3] = 1'b1; req_data[32*3 +: 32] = 32'hdeadbeef;
    step;
    checks++; if (enc_start !== 1'b1 || grant !== 4'b1000) begin failures++; $display("FAIL len0_start start=%b grant=%b exp 1/1000", enc_start, grant); end
    checks++; if (enc_data_av !== 1'b0 || req_data_ready !== 4'b0) begin failures++; $display("FAIL len0_nodata av=%b rdy=%b exp 0/0000", enc_data_av, req_data_ready); end
    step;
    checks++; if (req_data_ready !== 4'b0 || done !== 4'b0) begin failures++; $display("FAIL len0_wait rdy=%b done=%b exp 0000/0000", req_data_ready, done); end
    enc_fin = 1'b1;
    step;
    enc_fin = 1'b0;
    checks++; if (done !== 4'b1000) begin failures++; $display("FAIL len0_done got=%b exp=1000", done); end
    clear_inputs;
    step;
  endtask

  task automatic test_reset_mid;
    set_hdr(1, 16'h5555, 16'h6666, 16'd16, 1'b0);
    req[1] = 1'b1; req_data_valid[1] = 1'b1; req_data[32*1 +: 32] = 32'h01020304;
    step;
    step;
    checks++; if (enc_start !== 1'b0 || enc_data_av !== 1'b1 || grant !== 4'b0010) begin failures++; $display("FAIL rstmid_stream start=%b av=%b grant=%b exp 0/1/0010", enc_start, enc_data_av, grant); end
    reset = 1'b1;
    step;
    reset = 1'b0;
    set_hdr(0, 16'h7777, 16'h8888, 16'd4, 1'b0);
    set_hdr(2, 16'h9999, 16'haaaa, 16'd4, 1'b0);
    req = 4'b0111; req_data_valid = 4'b0111;
    req_data[32*0 +: 32] = 32'h0a0b0c0d;
    #1;
    checks++; if (grant !== 4'b0 || done !== 4'b0 || req_data_ready !== 4'b0 || enc_data_av !== 1'b0 || enc_start !== 1'b0) begin failures++; $display("FAIL rstmid_outputs grant=%b done=%b rdy=%b av=%b start=%b exp all 0", grant, done, req_data_ready, enc_data_av, enc_start); end
    checks++; if (enc_len !== 16'h0 || enc_src_port !== 16'h0) begin failures++; $display("FAIL rstmid_hdr len=%h src=%h exp 0/0", enc_len, enc_src_port); end
    step;
    checks++; if (grant !== 4'b0001 || done !== 4'b0 || enc_src_port !== 16'h7777) begin failures++; $display("FAIL rstmid_regrant grant=%b done=%b src=%h exp 0001/0000/7777", grant, done, enc_src_port); end
    step;
    enc_fin = 1'b1;
    step;
    enc_fin = 1'b0;
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL rstmid_done got=%b exp=0001", done); end
    clear_inputs;
    step;
  endtask

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    set_hdr(0, 16'hbbbb, 16'hcccc, 16'd4, 1'b0);
    req[0] = 1'b1; req_data_valid[0] = 1'b1;
    step;
    n = 0;
    while (done === 4'b0 && n < 40) begin
      step;
      n++;
    end
    checks++; if (n != 16) begin failures++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
    checks++; if (done !== 4'b0001 || error !== 1'b1 || req_data_ready !== 4'b0) begin failures++; $display("FAIL timeout_done done=%b err=%b rdy=%b exp 0001/1/0000", done, error, req_data_ready); end
    clear_inputs;
    step;
    checks++; if (error !== 1'b0 || grant !== 4'b0) begin failures++; $display("FAIL timeout_after err=%b grant=%b exp 0/0000", error, grant); end
  endtask
`endif

  initial begin
    clear_inputs;
    reset = 1'b1;
    test_reset;
    test_hello;
    test_round_robin;
    test_gap;
    test_len_zero;
    test_reset_mid;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Shares one `UDP_encoder` instance among `N_REQ` transmit requesters (socket/application ports).
- Round-robin arbitration picks a requester and latches its header (ports, length, checksum-disable) onto the encoder inputs.
- Pulses the encoder `start`, then streams the requester's 32-bit payload words with `data_av`.
- Waits for encoder `fin`, then hands completion back to the requester.
- Sits between the per-socket TX queues and the encoder, which feeds the IP layer.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1024: watchdog limit, used only with `UDP_TX_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N_REQ  per-requester packet request; held until its `done` pulse.
- `req_src_port`  in  16*N_REQ  source port, slice i = [16i+15:16i].
- `req_dest_port`  in  16*N_REQ  destination port.
- `req_len`  in  16*N_REQ  payload length in bytes.
- `req_no_chksum`  in  N_REQ  per-requester checksum disable.
- `req_data`  in  32*N_REQ  payload word, MSB = first byte.
- `req_data_valid`  in  N_REQ  word valid.
- `req_data_ready`  out  N_REQ  word accepted this cycle (valid & ready = transfer).
- `grant`  out  N_REQ  one-hot, owner of the encoder.
- `done`  out  N_REQ  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse alongside `done` on watchdog abort.
- `enc_src_port`, `enc_dest_port`, `enc_len`  out  16 each  to encoder.
- `enc_no_chksum`  out  1  to encoder.
- `enc_start`  out  1  to encoder.
- `enc_data`  out  32  to encoder.
- `enc_data_av`  out  1  to encoder.
- `enc_fin`  in  1  from encoder, end of packet.

## Operation
States are IDLE, START, STREAM, WAIT_FIN and DONE.
- **IDLE:** if any `req` is set, the round-robin picker chooses the first set bit after `last_grant`, wrapping. The scheduler registers `grant`, copies the header to the `enc_*` outputs, computes `words_left = (len+3)>>2` in 17-bit arithmetic (0xFFFF gives 0x4000) and goes to START.
- **START:** `enc_start=1` for exactly one cycle. `req_data_ready[g]=1` when `words_left>0`, and a valid word transfers in the same cycle. Next state:
  - `len==0` goes to WAIT_FIN with no data words.
  - Otherwise, STREAM if words remain after this cycle, else WAIT_FIN.
- **STREAM:** `req_data_ready[g]=1`; `enc_data_av = req_data_valid[g]`; `enc_data = req_data[g]`; `words_left` decrements per transfer. Gaps (valid low) are allowed and hold state. The last transfer goes to WAIT_FIN.
- **WAIT_FIN:** wait for `enc_fin`, then go to DONE. An `enc_fin` arriving earlier in START/STREAM is recorded, and WAIT_FIN exits on the next cycle.
- **DONE:** `done[g]=1` for one cycle; `last_grant` takes g; `grant` clears; go to IDLE.

Ordering and stability rules:
- Header outputs stay stable from START through DONE.
- `enc_data_av` and `req_data_ready` are 0 outside START/STREAM.
- Requester rules:
  - `req` deasserting mid-packet is ignored; the packet completes.
  - A new `req` from other requesters never preempts.
  - Simultaneous requests are served in RR order.
  - A requester re-requesting immediately after `done` goes behind the other pending requesters.

## Timing
- Reset state: state=IDLE, `last_grant=N_REQ-1` (requester 0 wins first), all outputs 0, header registers 0, `words_left=0`. Reset mid-packet aborts silently; no `done` is issued.
- `req` seen in IDLE at cycle t gives `grant` and `enc_*` header at t+1 and `enc_start` at t+1.
- With continuous valid, W words transfer on t+1..t+W.
- `enc_fin` at cycle f gives `done` at f+1. The earliest next `grant` is f+2.

## Configuration
`UDP_TX_SCHED_TIMEOUT_EN`:
- **Defined:** a cycle counter runs from START through WAIT_FIN and clears on state entry to IDLE.
  - On reaching `TIMEOUT_CYCLES`, the scheduler goes to DONE with `error=1` for that cycle.
  - Words still pending are discarded: `req_data_ready` is held 0 after abort.
- **Undefined:** no counter; `error` is tied 0; the scheduler waits on `enc_fin` forever.

## Structure
- Package `udp_pkg`:
  - state enum (IDLE, START, STREAM, WAIT_FIN, DONE);
  - `UDP_PORT_W=16`, `UDP_LEN_W=16`, `UDP_WORD_W=32`;
  - a words-from-length function.
- Sub-module `rr_arbiter`: combinational one-hot round-robin picker with inputs `req` and `last_grant`, output `pick`. It is reusable for the RX side.

## Test plan
- Single requester 1: ports 0xa08f/0x2694, len=11 ("Hello World"). Expect `enc_start` one cycle, 3 words 0x48656c6c, 0x6f20576f, 0x726c6400; `fin` → `done[1]` next cycle.
- All 4 requesters simultaneously, each len=4. Grant order is 0,1,2,3; the next round after requester 0 re-requests again starts at 0 only after 3.
- Requester 2, len=9, valid low for 2 cycles mid-stream. Expect `enc_data_av` gaps to match, exactly 3 transfers, `words_left` reaching 0.
- len=0. Expect `enc_start` with `enc_data_av=0`, no `req_data_ready`, then `done` after `fin`.
- Reset asserted during STREAM. Next cycle all outputs are 0, no `done`, and the next grant goes to requester 0.
- With the macro and `TIMEOUT_CYCLES=16`, `enc_fin` held 0. Expect `done` and `error` together, 16 cycles after START.
